// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage with req/ack data-memory port, stall and fault flags
module mem_access_stage #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic        mem_to_reg_in,
   input  logic        reg_write_in,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] write_data_in,
   input  logic [4:0]  write_reg_in,
   output logic        mem_to_reg_out,
   output logic        reg_write_out,
   output logic [31:0] read_data_out,
   output logic [31:0] alu_result_out,
   output logic [4:0]  write_reg_out,
   output logic        stall_out,
   output logic        mem_fault_out,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic          req_q;
   logic          fault_q;
   logic          h_read;
   logic          h_we;
   logic          h_m2r;
   logic          h_rw;
   logic [31:0]   h_alu;
   logic [31:0]   h_wdata;
   logic [4:0]    h_wreg;
   logic [31:0]   rdata_q;

   logic is_access;
   logic misaligned;
   logic timeout_hit;

   assign is_access   = mem_read_in | mem_write_in;
   assign misaligned  = (alu_result_in[1:0] != 2'b00);
   assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   // State register, timeout counter, request flop and holding registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         fault_q <= 1'b0;
         h_read  <= 1'b0;
         h_we    <= 1'b0;
         h_m2r   <= 1'b0;
         h_rw    <= 1'b0;
         h_alu   <= '0;
         h_wdata <= '0;
         h_wreg  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (state_d == REQ) begin
                  // A simultaneous read and write request is treated as a read.
                  h_read  <= mem_read_in;
                  h_we    <= mem_write_in & ~mem_read_in;
                  h_m2r   <= mem_to_reg_in;
                  h_rw    <= reg_write_in;
                  h_alu   <= alu_result_in;
                  h_wdata <= write_data_in;
                  h_wreg  <= write_reg_in;
                  rdata_q <= '0;
                  fault_q <= 1'b0;
                  cnt_q   <= '0;
                  req_q   <= 1'b1;
               end
            end
            REQ: begin
               if (dmem_ack) begin
                  req_q   <= 1'b0;
                  rdata_q <= h_read ? dmem_rdata : 32'd0;
               end else if (timeout_hit) begin
                  req_q   <= 1'b0;
                  fault_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DONE: begin
               fault_q <= 1'b0;
            end
            default: begin
               req_q <= 1'b0;
            end
         endcase
      end
   end

   // Next-state and all stage outputs; everything is forced to 0 while reset is high
   always_comb begin
      state_d        = state_q;
      mem_to_reg_out = 1'b0;
      reg_write_out  = 1'b0;
      read_data_out  = '0;
      alu_result_out = '0;
      write_reg_out  = '0;
      stall_out      = 1'b0;
      mem_fault_out  = 1'b0;
      dmem_req       = 1'b0;
      dmem_we        = 1'b0;
      dmem_addr      = '0;
      dmem_wdata     = '0;
      if (!reset) begin
         dmem_req = req_q;
         if (req_q) begin
            dmem_we    = h_we;
            dmem_addr  = {h_alu[31:2], 2'b00};
            dmem_wdata = h_wdata;
         end
         case (state_q)
            IDLE: begin
               if (is_access && !misaligned) begin
                  // Aligned access: stall and hand a bubble to MEM/WB.
                  state_d   = REQ;
                  stall_out = 1'b1;
               end else begin
                  mem_to_reg_out = mem_to_reg_in;
                  reg_write_out  = reg_write_in & ~is_access;
                  alu_result_out = alu_result_in;
                  write_reg_out  = write_reg_in;
                  mem_fault_out  = is_access;
               end
            end
            REQ: begin
               stall_out = 1'b1;
               if (dmem_ack || timeout_hit) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               state_d        = IDLE;
               mem_to_reg_out = h_m2r;
               reg_write_out  = h_rw & ~fault_q;
               read_data_out  = rdata_q;
               alu_result_out = h_alu;
               write_reg_out  = h_wreg;
               mem_fault_out  = fault_q;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_read_in = 1'b0;
   logic        mem_write_in = 1'b0;
   logic        mem_to_reg_in = 1'b0;
   logic        reg_write_in = 1'b0;
   logic [31:0] alu_result_in = '0;
   logic [31:0] write_data_in = '0;
   logic [4:0]  write_reg_in = '0;
   logic        mem_to_reg_out;
   logic        reg_write_out;
   logic [31:0] read_data_out;
   logic [31:0] alu_result_out;
   logic [4:0]  write_reg_out;
   logic        stall_out;
   logic        mem_fault_out;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = '0;

   typedef struct packed {
      logic        rw;
      logic        m2r;
      logic        fault;
      logic [31:0] alu;
      logic [4:0]  wreg;
      logic [31:0] rdata;
   } out_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_t;

   out_t exp_q[$];
   mem_t mem_q[$];
   int   checks = 0;
   int   failures = 0;
   logic prev_req = 1'b0;

   mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset),
      .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
      .alu_result_in(alu_result_in), .write_data_in(write_data_in),
      .write_reg_in(write_reg_in),
      .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
      .read_data_out(read_data_out), .alu_result_out(alu_result_out),
      .write_reg_out(write_reg_out), .stall_out(stall_out),
      .mem_fault_out(mem_fault_out),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Output monitor: every non-stalled cycle out of reset is one MEM/WB capture
   always @(negedge clk) begin
      if (!reset && !stall_out) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 128'(1), 128'(0));
         end else begin
            out_t e;
            out_t a;
            e = exp_q.pop_front();
            a = '{rw: reg_write_out, m2r: mem_to_reg_out, fault: mem_fault_out,
                  alu: alu_result_out, wreg: write_reg_out, rdata: read_data_out};
            check("wb_output", 128'(a), 128'(e));
         end
      end
   end

   // Memory-port monitor: request fields checked on every REQ cycle, popped when req drops
   always @(negedge clk) begin
      if (!reset && dmem_req) begin
         if (mem_q.size() == 0) begin
            check("unexpected_dmem_req", 128'(1), 128'(0));
         end else begin
            mem_t a;
            a = '{we: dmem_we, addr: dmem_addr, wdata: dmem_wdata};
            check("dmem_fields", 128'(a), 128'(mem_q[0]));
         end
      end
      if (prev_req && !dmem_req && mem_q.size() != 0) void'(mem_q.pop_front());
      prev_req = dmem_req;
   end

   // Present one instruction until the stage releases it; ack_after=0 means never ack
   task automatic issue(input logic rd, input logic wr, input logic m2r, input logic rw,
                        input logic [31:0] alu, input logic [31:0] wdata, input logic [4:0] wreg,
                        input int ack_after, input logic [31:0] rdv,
                        input out_t e, input logic has_mem, input mem_t me,
                        output int stall_c, output int req_c, output int bad_rw);
      logic finished;
      mem_read_in   = rd;
      mem_write_in  = wr;
      mem_to_reg_in = m2r;
      reg_write_in  = rw;
      alu_result_in = alu;
      write_data_in = wdata;
      write_reg_in  = wreg;
      exp_q.push_back(e);
      if (has_mem) mem_q.push_back(me);
      stall_c  = 0;
      req_c    = 0;
      bad_rw   = 0;
      finished = 1'b0;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         if (dmem_req) begin
            req_c++;
            if (req_c == ack_after) begin
               dmem_ack   = 1'b1;
               dmem_rdata = rdv;
            end else begin
               dmem_ack = 1'b0;
            end
         end else if (n > 0) begin
            dmem_ack = 1'b0;
         end
         if (!stall_out) begin
            finished = 1'b1;
            break;
         end
         stall_c++;
         if (reg_write_out) bad_rw++;
      end
      if (!finished) check("issue_timeout", 128'(0), 128'(1));
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
   endtask

   initial begin
      int sc;
      int rc;
      int br;
      mem_t none;
      none = '0;

      // Reset held with a load pending
      mem_read_in   = 1'b1;
      mem_to_reg_in = 1'b1;
      reg_write_in  = 1'b1;
      alu_result_in = 32'h40;
      write_reg_in  = 5'd9;
      dmem_ack      = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs",
            128'({mem_to_reg_out, reg_write_out, read_data_out, alu_result_out, write_reg_out,
                  stall_out, mem_fault_out, dmem_req, dmem_we, dmem_addr, dmem_wdata}),
            128'(0));
      @(posedge clk);
      #1;
      reset    = 1'b0;
      dmem_ack = 1'b0;

      // Non-memory pass-through right after reset release
      issue(0, 0, 0, 1, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0,
            '{rw: 1, m2r: 0, fault: 0, alu: 32'h1234, wreg: 5, rdata: 0}, 0, none, sc, rc, br);
      check("passthru_stall", 128'(sc), 128'(0));
      check("after_reset_req", 128'(rc), 128'(0));

      // Load acked on third REQ cycle
      issue(1, 0, 1, 1, 32'h40, 32'h0, 5'd9, 3, 32'hDEAD_BEEF,
            '{rw: 1, m2r: 1, fault: 0, alu: 32'h40, wreg: 9, rdata: 32'hDEAD_BEEF},
            1, '{we: 0, addr: 32'h40, wdata: 32'h0}, sc, rc, br);
      check("load_req_cycles", 128'(rc), 128'(3));
      check("load_stall_cycles", 128'(sc), 128'(4));
      check("load_rw_in_stall", 128'(br), 128'(0));

      // Store with immediate ack; read data on the bus must not reach writeback
      issue(0, 1, 0, 0, 32'h80, 32'h1234_5678, 5'd0, 1, 32'hFFFF_FFFF,
            '{rw: 0, m2r: 0, fault: 0, alu: 32'h80, wreg: 0, rdata: 0},
            1, '{we: 1, addr: 32'h80, wdata: 32'h1234_5678}, sc, rc, br);
      check("store_req_cycles", 128'(rc), 128'(1));
      check("store_stall_cycles", 128'(sc), 128'(2));

      // Misaligned load: one-cycle fault, no request
      issue(1, 0, 1, 1, 32'h42, 32'h0, 5'd7, 0, 32'h0,
            '{rw: 0, m2r: 1, fault: 1, alu: 32'h42, wreg: 7, rdata: 0}, 0, none, sc, rc, br);
      check("misaligned_req", 128'(rc), 128'(0));
      check("misaligned_stall", 128'(sc), 128'(0));

      // Read and write together behave as a read
      issue(1, 1, 1, 1, 32'h0C, 32'h5555_AAAA, 5'd12, 1, 32'hA5A5_0001,
            '{rw: 1, m2r: 1, fault: 0, alu: 32'h0C, wreg: 12, rdata: 32'hA5A5_0001},
            1, '{we: 0, addr: 32'h0C, wdata: 32'h5555_AAAA}, sc, rc, br);
      check("rw_both_req_cycles", 128'(rc), 128'(1));

      // Timeout: never acked
      issue(1, 0, 1, 1, 32'h100, 32'h0, 5'd4, 0, 32'h0,
            '{rw: 0, m2r: 1, fault: 1, alu: 32'h100, wreg: 4, rdata: 0},
            1, '{we: 0, addr: 32'h100, wdata: 32'h0}, sc, rc, br);
      check("timeout_req_cycles", 128'(rc), 128'(4));
      check("timeout_stall_cycles", 128'(sc), 128'(5));
      check("timeout_rw_in_stall", 128'(br), 128'(0));

      // Late ack in IDLE after the timeout must be ignored
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hBAD0_BAD0;
      issue(0, 0, 0, 1, 32'h77, 32'h0, 5'd3, 0, 32'h0,
            '{rw: 1, m2r: 0, fault: 0, alu: 32'h77, wreg: 3, rdata: 0}, 0, none, sc, rc, br);
      check("late_ack_req", 128'(rc), 128'(0));
      issue(0, 0, 1, 0, 32'h88, 32'h0, 5'd2, 0, 32'h0,
            '{rw: 0, m2r: 1, fault: 0, alu: 32'h88, wreg: 2, rdata: 0}, 0, none, sc, rc, br);
      check("after_late_ack_req", 128'(rc), 128'(0));
      check("after_late_ack_stall", 128'(sc), 128'(0));

      reset = 1'b1;
      @(negedge clk);
      check("exp_queue_drained", 128'(exp_q.size()), 128'(0));
      check("mem_queue_drained", 128'(mem_q.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
